// File: rtl/jtag_pkg.sv
// Shared types and constants for the JTAG TAP / RISC-V DTM.
package jtag_pkg;

  typedef enum logic [3:0] {
    TAP_TLR, TAP_RTI,
    TAP_SEL_DR, TAP_CAP_DR, TAP_SH_DR, TAP_EX1_DR, TAP_PA_DR, TAP_EX2_DR, TAP_UPD_DR,
    TAP_SEL_IR, TAP_CAP_IR, TAP_SH_IR, TAP_EX1_IR, TAP_PA_IR, TAP_EX2_IR, TAP_UPD_IR
  } tap_state_t;

  localparam logic [4:0] IR_CODE_IDCODE = 5'h01;
  localparam logic [4:0] IR_CODE_DTMCS  = 5'h10;
  localparam logic [4:0] IR_CODE_DMI    = 5'h11;

  typedef enum logic [1:0] {DMI_NOP = 2'd0, DMI_READ = 2'd1, DMI_WRITE = 2'd2, DMI_RSVD = 2'd3} dmi_op_t;
  typedef enum logic [1:0] {DMISTAT_OK = 2'd0, DMISTAT_FAIL = 2'd2, DMISTAT_BUSY = 2'd3} dmistat_t;
  typedef enum logic [1:0] {DMI_IDLE, DMI_REQ, DMI_WAIT} dmi_state_t;
  typedef enum logic [1:0] {SEL_BYPASS, SEL_IDCODE, SEL_DTMCS, SEL_DMI} dr_sel_t;

  localparam logic [3:0] DTM_VERSION = 4'h1;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller: 16-state machine plus decoded capture/shift/update strobes.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck_i,
  input  logic       ntrst_i,
  input  logic       tms_i,
  output tap_state_t state,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr
);

  tap_state_t state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      TAP_TLR:    state_nxt = tms_i ? TAP_TLR    : TAP_RTI;
      TAP_RTI:    state_nxt = tms_i ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR: state_nxt = tms_i ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR: state_nxt = tms_i ? TAP_EX1_DR : TAP_SH_DR;
      TAP_SH_DR:  state_nxt = tms_i ? TAP_EX1_DR : TAP_SH_DR;
      TAP_EX1_DR: state_nxt = tms_i ? TAP_UPD_DR : TAP_PA_DR;
      TAP_PA_DR:  state_nxt = tms_i ? TAP_EX2_DR : TAP_PA_DR;
      TAP_EX2_DR: state_nxt = tms_i ? TAP_UPD_DR : TAP_SH_DR;
      TAP_UPD_DR: state_nxt = tms_i ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR: state_nxt = tms_i ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR: state_nxt = tms_i ? TAP_EX1_IR : TAP_SH_IR;
      TAP_SH_IR:  state_nxt = tms_i ? TAP_EX1_IR : TAP_SH_IR;
      TAP_EX1_IR: state_nxt = tms_i ? TAP_UPD_IR : TAP_PA_IR;
      TAP_PA_IR:  state_nxt = tms_i ? TAP_EX2_IR : TAP_PA_IR;
      TAP_EX2_IR: state_nxt = tms_i ? TAP_UPD_IR : TAP_SH_IR;
      TAP_UPD_IR: state_nxt = tms_i ? TAP_SEL_DR : TAP_RTI;
      default:    state_nxt = TAP_TLR;
    endcase
  end

  always_ff @(posedge tck_i or negedge ntrst_i) begin
    if (!ntrst_i) state <= TAP_TLR;
    else          state <= state_nxt;
  end

  // Strobes mark the state whose exiting edge performs the action.
  assign capture_ir = (state == TAP_CAP_IR);
  assign shift_ir   = (state == TAP_SH_IR);
  assign update_ir  = (state == TAP_UPD_IR);
  assign capture_dr = (state == TAP_CAP_DR);
  assign shift_dr   = (state == TAP_SH_DR);
  assign update_dr  = (state == TAP_UPD_DR);

endmodule

// File: rtl/jtag_dtm_tap.sv
// JTAG TAP with RISC-V Debug 0.13 DTM: IDCODE, DTMCS, DMI and BYPASS data registers,
// and a valid/ready DMI request/response engine in the TCK domain.
module jtag_dtm_tap
  import jtag_pkg::*;
#(
  parameter logic [31:0] IDCODE    = 32'h1DEAD3FF,
  parameter int unsigned IR_LEN    = 5,
  parameter int unsigned ABITS     = 7,
  parameter logic [2:0]  IDLE_HINT = 3'd1
) (
  input  logic             tck_i,
  input  logic             ntrst_i,
  input  logic             tms_i,
  input  logic             tdi_i,
  output logic             tdo_o,
  output logic             tdo_en_o,
  output logic             dmi_req_valid_o,
  input  logic             dmi_req_ready_i,
  output logic [ABITS-1:0] dmi_req_addr_o,
  output logic [31:0]      dmi_req_data_o,
  output logic [1:0]       dmi_req_op_o,
  input  logic             dmi_resp_valid_i,
  output logic             dmi_resp_ready_o,
  input  logic [31:0]      dmi_resp_data_i,
  input  logic [1:0]       dmi_resp_op_i
);

  localparam int unsigned DR_W = ABITS + 34;
  localparam logic [5:0]  ABITS_FIELD = 6'(ABITS);
  localparam logic [IR_LEN-1:0] IR_IDCODE = IR_LEN'(IR_CODE_IDCODE);
  localparam logic [IR_LEN-1:0] IR_DTMCS  = IR_LEN'(IR_CODE_DTMCS);
  localparam logic [IR_LEN-1:0] IR_DMI    = IR_LEN'(IR_CODE_DMI);

  tap_state_t tap_state;
  logic capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr;

  jtag_tap_fsm u_tap_fsm (
    .tck_i      (tck_i),
    .ntrst_i    (ntrst_i),
    .tms_i      (tms_i),
    .state      (tap_state),
    .capture_ir (capture_ir),
    .shift_ir   (shift_ir),
    .update_ir  (update_ir),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr)
  );

  logic [IR_LEN-1:0] ir_q, ir_sr;
  logic [DR_W-1:0]   dr_sr, dr_capture, dr_shift;
  dr_sel_t           dr_sel;
  dmi_state_t        dmi_state;
  dmistat_t          dmistat;
  logic [ABITS-1:0]  last_addr;
  logic [31:0]       last_rdata;
  logic [1:0]        op_cap;
  logic [31:0]       dtmcs_word;

  always_comb begin
    dr_sel = SEL_BYPASS;
    if      (ir_q == IR_IDCODE) dr_sel = SEL_IDCODE;
    else if (ir_q == IR_DTMCS)  dr_sel = SEL_DTMCS;
    else if (ir_q == IR_DMI)    dr_sel = SEL_DMI;
  end

  assign op_cap     = (dmi_state != DMI_IDLE) ? 2'd3 : dmistat;
  assign dtmcs_word = {14'd0, 1'b0, 1'b0, 1'b0, IDLE_HINT, dmistat, ABITS_FIELD, DTM_VERSION};

  always_comb begin
    dr_capture = '0;
    dr_shift   = dr_sr;
    case (dr_sel)
      SEL_IDCODE: begin
        dr_capture     = DR_W'(IDCODE);
        dr_shift[31:0] = {tdi_i, dr_sr[31:1]};
      end
      SEL_DTMCS: begin
        dr_capture     = DR_W'(dtmcs_word);
        dr_shift[31:0] = {tdi_i, dr_sr[31:1]};
      end
      SEL_DMI: begin
        dr_capture = {last_addr, last_rdata, op_cap};
        dr_shift   = {tdi_i, dr_sr[DR_W-1:1]};
      end
      default: dr_shift[0] = tdi_i;
    endcase
  end

  always_ff @(posedge tck_i or negedge ntrst_i) begin
    if (!ntrst_i) begin
      ir_q  <= IR_IDCODE;
      ir_sr <= '0;
      dr_sr <= '0;
    end else begin
      if (capture_ir)    ir_sr <= IR_LEN'(2'b01);
      else if (shift_ir) ir_sr <= {tdi_i, ir_sr[IR_LEN-1:1]};
      if (tap_state == TAP_TLR) ir_q <= IR_IDCODE;
      else if (update_ir)       ir_q <= ir_sr;
      if (capture_dr)    dr_sr <= dr_capture;
      else if (shift_dr) dr_sr <= dr_shift;
    end
  end

  logic             dtmcs_upd, dmi_upd, dmireset, dmihardreset;
  logic [1:0]       scan_op;
  logic [31:0]      scan_data;
  logic [ABITS-1:0] scan_addr;

  assign dtmcs_upd    = update_dr && (dr_sel == SEL_DTMCS);
  assign dmireset     = dtmcs_upd && dr_sr[16];
  assign dmihardreset = dtmcs_upd && dr_sr[17];
  assign dmi_upd      = update_dr && (dr_sel == SEL_DMI);
  assign scan_op      = dr_sr[1:0];
  assign scan_data    = dr_sr[33:2];
  assign scan_addr    = dr_sr[DR_W-1:34];

  // Later assignments win: busy over a same-edge failure, resets over both.
  always_ff @(posedge tck_i or negedge ntrst_i) begin
    if (!ntrst_i) begin
      dmi_state        <= DMI_IDLE;
      dmistat          <= DMISTAT_OK;
      dmi_req_valid_o  <= 1'b0;
      dmi_resp_ready_o <= 1'b0;
      dmi_req_addr_o   <= '0;
      dmi_req_data_o   <= '0;
      dmi_req_op_o     <= '0;
      last_addr        <= '0;
      last_rdata       <= '0;
    end else begin
      case (dmi_state)
        DMI_IDLE: begin
          if (dmi_upd && dmistat == DMISTAT_OK &&
              (scan_op == DMI_READ || scan_op == DMI_WRITE)) begin
            dmi_req_addr_o  <= scan_addr;
            dmi_req_data_o  <= scan_data;
            dmi_req_op_o    <= scan_op;
            last_addr       <= scan_addr;
            dmi_req_valid_o <= 1'b1;
            dmi_state       <= DMI_REQ;
          end
        end
        DMI_REQ: begin
          if (dmi_req_ready_i) begin
            dmi_req_valid_o  <= 1'b0;
            dmi_resp_ready_o <= 1'b1;
            dmi_state        <= DMI_WAIT;
          end
        end
        DMI_WAIT: begin
          if (dmi_resp_valid_i) begin
            dmi_resp_ready_o <= 1'b0;
            dmi_state        <= DMI_IDLE;
            if (dmi_req_op_o == DMI_READ) last_rdata <= dmi_resp_data_i;
            if (dmi_resp_op_i[1] && dmistat == DMISTAT_OK) dmistat <= DMISTAT_FAIL;
          end
        end
        default: dmi_state <= DMI_IDLE;
      endcase
      if (dmi_upd && dmistat == DMISTAT_OK && dmi_state != DMI_IDLE) dmistat <= DMISTAT_BUSY;
      if (dmireset || dmihardreset) dmistat <= DMISTAT_OK;
      if (dmihardreset) begin
        dmi_state        <= DMI_IDLE;
        dmi_req_valid_o  <= 1'b0;
        dmi_resp_ready_o <= 1'b0;
      end
    end
  end

  logic ir_path, dr_path;
  assign ir_path  = (tap_state == TAP_CAP_IR) || (tap_state == TAP_SH_IR) || (tap_state == TAP_EX1_IR);
  assign dr_path  = (tap_state == TAP_CAP_DR) || (tap_state == TAP_SH_DR) || (tap_state == TAP_EX1_DR);
  assign tdo_o    = ir_path ? ir_sr[0] : (dr_path ? dr_sr[0] : 1'b0);
  assign tdo_en_o = shift_ir || shift_dr;

endmodule
